// File: rtl/trivium_pkg.sv
// Shared definitions for the Trivium stream decryptor: state width, warm-up
// length, steps per advance, tap positions, FSM state type and key/iv byte
// reversal helper.
package trivium_pkg;

  localparam int STATE_W       = 288;
  localparam int WARMUP_CYCLES = 144;
  localparam int STEPS_PER_ADV = 8;

  // Last value of the warm-up cycle counter before leaving WARMUP.
  localparam logic [7:0] WARMUP_LAST = 8'(WARMUP_CYCLES - 1);

  // Output taps, AND-gate taps and feedback taps of the three registers.
  localparam int T1_OUT_A = 65;
  localparam int T1_OUT_B = 92;
  localparam int T1_AND_A = 90;
  localparam int T1_AND_B = 91;
  localparam int T1_FB    = 170;

  localparam int T2_OUT_A = 161;
  localparam int T2_OUT_B = 176;
  localparam int T2_AND_A = 174;
  localparam int T2_AND_B = 175;
  localparam int T2_FB    = 263;

  localparam int T3_OUT_A = 242;
  localparam int T3_OUT_B = 287;
  localparam int T3_AND_A = 285;
  localparam int T3_AND_B = 286;
  localparam int T3_FB    = 68;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } fsm_state_e;

  // Byte 0 arrives in bits [79:72]; the cipher wants it in bits [7:0].
  function automatic logic [79:0] byte_reverse80(input logic [79:0] v);
    logic [79:0] r;
    for (int i = 0; i < 10; i++) begin
      r[8*i +: 8] = v[79-8*i -: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/trivium_round.sv
// One Trivium step: keystream bit z from the current state and the shifted
// next state with the three nonlinear feedback bits inserted.
module trivium_round
  import trivium_pkg::*;
(
  input  logic [STATE_W-1:0] s_i,
  output logic [STATE_W-1:0] s_o,
  output logic               z_o
);

  logic t1;
  logic t2;
  logic t3;
  logic t1_fb;
  logic t2_fb;
  logic t3_fb;

  // Output taps, keystream bit, feedback terms and register shift.
  always_comb begin
    t1    = s_i[T1_OUT_A] ^ s_i[T1_OUT_B];
    t2    = s_i[T2_OUT_A] ^ s_i[T2_OUT_B];
    t3    = s_i[T3_OUT_A] ^ s_i[T3_OUT_B];
    z_o   = t1 ^ t2 ^ t3;
    t1_fb = t1 ^ (s_i[T1_AND_A] & s_i[T1_AND_B]) ^ s_i[T1_FB];
    t2_fb = t2 ^ (s_i[T2_AND_A] & s_i[T2_AND_B]) ^ s_i[T2_FB];
    t3_fb = t3 ^ (s_i[T3_AND_A] & s_i[T3_AND_B]) ^ s_i[T3_FB];
    s_o   = {s_i[286:177], t2_fb, s_i[175:93], t1_fb, s_i[91:0], t3_fb};
  end

endmodule

// File: rtl/trivium_stream_dec.sv
// Trivium byte-stream decryptor. A start pulse loads key/iv/msg_len, the
// cipher warms up for 1152 steps, then each accepted ciphertext byte is XORed
// with the next keystream byte (8 steps, LSB first) and presented one cycle
// later. Define TRIVIUM_KS_OUT_EN to add the ks_data keystream output.
//
// Handshakes: a byte moves on a port when valid and ready are both high at a
// rising edge. out_valid/out_data stay stable until out_ready is seen;
// in_ready = RUN && (!out_valid || out_ready), so a new byte is only taken
// when the output slot is free or being emptied in the same cycle.
module trivium_stream_dec
  import trivium_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [79:0] key,
  input  logic [79:0] iv,
  input  logic [15:0] msg_len,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        busy,
  output logic        done,
`ifdef TRIVIUM_KS_OUT_EN
  output logic [7:0]  ks_data,
`endif
  output fsm_state_e  dbg_state
);

  fsm_state_e         state_q, state_d;
  logic [STATE_W-1:0] s_q, s_d;
  logic [7:0]         warm_q, warm_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [15:0]        len_q, len_d;
  logic               out_valid_q, out_valid_d;
  logic [7:0]         out_data_q, out_data_d;
  logic               done_q, done_d;
`ifdef TRIVIUM_KS_OUT_EN
  logic [7:0]         ks_q, ks_d;
`endif

  logic [STEPS_PER_ADV:0][STATE_W-1:0] chain;
  logic [7:0]                          ks_byte;
  logic [STATE_W-1:0]                  load_state;
  logic                                accept;
  logic                                last_byte;

  assign chain[0] = s_q;

  // Eight rounds in series give one byte of keystream per advance.
  for (genvar g = 0; g < STEPS_PER_ADV; g++) begin : g_round
    trivium_round u_round (
      .s_i (chain[g]),
      .s_o (chain[g+1]),
      .z_o (ks_byte[g])
    );
  end

  assign load_state = {3'b111, 112'b0, byte_reverse80(iv), 13'b0, byte_reverse80(key)};
  assign in_ready   = (state_q == ST_RUN) && (!out_valid_q || out_ready);
  assign accept     = in_valid && in_ready;
  assign last_byte  = ({1'b0, cnt_q} + 17'd1) == {1'b0, len_q};

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign done       = done_q;
  assign busy       = (state_q == ST_WARMUP) || (state_q == ST_RUN);
  assign dbg_state  = state_q;
`ifdef TRIVIUM_KS_OUT_EN
  assign ks_data    = ks_q;
`endif

  // Next-state logic: session load, warm-up stepping, byte decryption.
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    warm_d      = warm_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;
`ifdef TRIVIUM_KS_OUT_EN
    ks_d        = ks_q;
`endif
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (start) begin
      state_d = ST_WARMUP;
      s_d     = load_state;
      warm_d  = 8'd0;
      cnt_d   = 16'd0;
      len_d   = msg_len;
      // A restart drops any byte of the aborted session still waiting.
      if (state_q != ST_IDLE) begin
        out_valid_d = 1'b0;
      end
    end else begin
      case (state_q)
        ST_WARMUP: begin
          s_d    = chain[STEPS_PER_ADV];
          warm_d = warm_q + 8'd1;
          if (warm_q == WARMUP_LAST) begin
            if (len_q == 16'd0) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (accept) begin
            s_d         = chain[STEPS_PER_ADV];
            out_data_d  = in_data ^ ks_byte;
            out_valid_d = 1'b1;
            cnt_d       = cnt_q + 16'd1;
`ifdef TRIVIUM_KS_OUT_EN
            ks_d        = ks_byte;
`endif
            if (last_byte) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      s_q         <= '0;
      warm_q      <= 8'd0;
      cnt_q       <= 16'd0;
      len_q       <= 16'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
      done_q      <= 1'b0;
`ifdef TRIVIUM_KS_OUT_EN
      ks_q        <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      warm_q      <= warm_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
`ifdef TRIVIUM_KS_OUT_EN
      ks_q        <= ks_d;
`endif
    end
  end

endmodule

// File: tb/tb_trivium_stream_dec.sv
// Bench for trivium_stream_dec: table of sessions plus hand-written restart
// and reset-abort sequences, scored against a reference Trivium model.
module tb_trivium_stream_dec;
  import trivium_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [79:0] key;
  logic [79:0] iv;
  logic [15:0] msg_len;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        busy;
  logic        done;
  fsm_state_e  dbg_state;
`ifdef TRIVIUM_KS_OUT_EN
  logic [7:0]  ks_data;
  logic [7:0]  ks_exp_q[$];
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] pt_a[64];
  logic [7:0] ct_a[64];
  logic [7:0] ks_a[64];

  typedef struct {
    logic [79:0] key;
    logic [79:0] iv;
    int          len;
    int          mode;
    bit          ramp;
  } vec_t;

  vec_t tbl[6];

  trivium_stream_dec dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .key       (key),
    .iv        (iv),
    .msg_len   (msg_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done),
`ifdef TRIVIUM_KS_OUT_EN
    .ks_data   (ks_data),
`endif
    .dbg_state (dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Watchdog so the run always terminates.
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model in the classic 1-based numbering: bit n of a is s_n.
  function automatic logic [287:0] g_load(input logic [79:0] k, input logic [79:0] v);
    logic [79:0] kl;
    logic [79:0] vl;
    for (int i = 0; i < 10; i++) begin
      kl[8*i +: 8] = k[79-8*i -: 8];
      vl[8*i +: 8] = v[79-8*i -: 8];
    end
    return {3'b111, 112'b0, vl, 13'b0, kl};
  endfunction

  function automatic logic [287:0] g_adv(input logic [287:0] s_in, output logic [7:0] ks);
    logic [288:1] a;
    logic t1, t2, t3;
    a = s_in;
    for (int k = 0; k < 8; k++) begin
      t1 = a[66] ^ a[93];
      t2 = a[162] ^ a[177];
      t3 = a[243] ^ a[288];
      ks[k] = t1 ^ t2 ^ t3;
      t1 = t1 ^ (a[91] & a[92]) ^ a[171];
      t2 = t2 ^ (a[175] & a[176]) ^ a[264];
      t3 = t3 ^ (a[286] & a[287]) ^ a[69];
      for (int i = 288; i > 178; i--) a[i] = a[i-1];
      a[178] = t2;
      for (int i = 177; i > 94; i--) a[i] = a[i-1];
      a[94] = t1;
      for (int i = 93; i > 1; i--) a[i] = a[i-1];
      a[1] = t3;
    end
    return a;
  endfunction

  // Drive one session; returns early after abort_at accepts (abort_at >= 0).
  task automatic run_session(input logic [79:0] k, input logic [79:0] v, input int len,
                             input int mode, input int abort_at, input bit ramp);
    logic [287:0] gs;
    logic [7:0]   kb;
    int           acc = 0;
    int           hold = 0;
    int           first_rdy = -1;
    int           cyc;
    bit           over = 0;
    bit           done_pend = 0;
    bit           exp_ready;
    fsm_state_e   exp_state;

    gs = g_load(k, v);
    for (int i = 0; i < 144; i++) gs = g_adv(gs, kb);
    for (int j = 0; j < len; j++) begin
      pt_a[j] = ramp ? 8'(j) : 8'($urandom_range(0, 255));
      gs = g_adv(gs, kb);
      ks_a[j] = kb;
      ct_a[j] = pt_a[j] ^ kb;
    end
    exp_q.delete();
`ifdef TRIVIUM_KS_OUT_EN
    ks_exp_q.delete();
`endif

    @(posedge clk); #1;
    start = 1'b1; key = k; iv = v; msg_len = 16'(len);
    in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1; in_data = ct_a[0]; out_ready = 1'b1;

    for (cyc = 1; cyc <= 2500; cyc++) begin
      @(negedge clk);
      exp_ready = (cyc >= 145) && !over && (exp_q.size() == 0 || out_ready);
      exp_state = over ? ST_IDLE : ((cyc <= 144) ? ST_WARMUP : ST_RUN);
      chk("in_ready", 32'(in_ready), 32'(exp_ready));
      chk("busy", 32'(busy), 32'(!over));
      chk("done", 32'(done), 32'(done_pend));
      chk("state", 32'(dbg_state), 32'(exp_state));
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      if (in_ready && first_rdy < 0) first_rdy = cyc;
      if (exp_q.size() != 0) begin
        chk("out_data", 32'(out_data), 32'(exp_q[0]));
`ifdef TRIVIUM_KS_OUT_EN
        chk("ks_data", 32'(ks_data), 32'(ks_exp_q[0]));
`endif
      end
      done_pend = 0;
      if (exp_q.size() != 0 && out_ready) begin
        void'(exp_q.pop_front());
`ifdef TRIVIUM_KS_OUT_EN
        void'(ks_exp_q.pop_front());
`endif
      end
      if (exp_ready && in_valid) begin
        exp_q.push_back(pt_a[acc]);
`ifdef TRIVIUM_KS_OUT_EN
        ks_exp_q.push_back(ks_a[acc]);
`endif
        acc++;
        if (acc == len) begin
          done_pend = 1;
          over = 1;
        end
      end
      if (len == 0 && cyc == 144) begin
        done_pend = 1;
        over = 1;
      end
      if (abort_at >= 0 && acc == abort_at) return;
      if (over && exp_q.size() == 0 && !done_pend) break;
      @(posedge clk); #1;
      in_data = (acc < len) ? ct_a[acc] : 8'($urandom_range(0, 255));
      case (mode)
        1: begin
          in_valid  = 1'($urandom_range(0, 1));
          out_ready = ($urandom_range(0, 3) != 0);
        end
        2: begin
          in_valid = 1'b1;
          if (acc == 2 && exp_q.size() != 0 && hold < 5) begin
            out_ready = 1'b0;
            hold++;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: begin
          in_valid  = 1'b1;
          out_ready = 1'b1;
        end
      endcase
    end
    chk("session_complete", 32'(over && exp_q.size() == 0), 32'd1);
    if (len > 0) chk("first_in_ready_cycle", 32'(first_rdy), 32'd145);
    else         chk("no_in_ready_len0", 32'(first_rdy), 32'hFFFF_FFFF);
    if (mode == 2) chk("bp_hold_cycles", 32'(hold), 32'd5);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset block.
    reset = 1'b1; start = 1'b0; key = '0; iv = '0; msg_len = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk); #1;
    reset = 1'b0;

    tbl[0] = '{key: 80'h0, iv: 80'h0, len: 16, mode: 0, ramp: 1'b1};
    tbl[1] = '{key: 80'h0123_4567_89AB_CDEF_0011, iv: 80'hFEDC_BA98_7654_3210_A5A5, len: 12, mode: 1, ramp: 1'b0};
    tbl[2] = '{key: 80'h8000_0000_0000_0000_0001, iv: 80'h0000_0000_0000_0000_0080, len: 8, mode: 2, ramp: 1'b0};
    tbl[3] = '{key: 80'h1111_2222_3333_4444_5555, iv: 80'h6666_7777_8888_9999_AAAA, len: 0, mode: 0, ramp: 1'b0};
    tbl[4] = '{key: 80'hFFFF_FFFF_FFFF_FFFF_FFFF, iv: 80'hFFFF_FFFF_FFFF_FFFF_FFFF, len: 1, mode: 1, ramp: 1'b0};
    tbl[5] = '{key: 80'hDEAD_BEEF_CAFE_F00D_1234, iv: 80'h0BAD_F00D_5555_AAAA_0F0F, len: 20, mode: 1, ramp: 1'b0};

    for (int t = 0; t < 6; t++) begin
      run_session(tbl[t].key, tbl[t].iv, tbl[t].len, tbl[t].mode, -1, tbl[t].ramp);
    end

    // Restart while RUN after byte 3: new session must start from byte 0.
    run_session(80'hA5A5_0000_FFFF_1234_5678, 80'h0102_0304_0506_0708_090A, 10, 0, 3, 1'b0);
    run_session(80'h1357_9BDF_0246_8ACE_1122, 80'h99AA_BBCC_DDEE_FF00_1122, 10, 1, -1, 1'b0);

    // Reset mid-RUN: outputs drop immediately, next session looks fresh.
    run_session(80'hA5A5_0000_FFFF_1234_5678, 80'h0102_0304_0506_0708_090A, 10, 0, 3, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1; in_valid = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_no_done", 32'(done), 32'd0);
    run_session(80'hA5A5_0000_FFFF_1234_5678, 80'h0102_0304_0506_0708_090A, 10, 0, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
